or1k_mul_pipelined_cappuccino: RTL
==================================

# or1k_mul_pipelined_cappuccino

Fully pipelined three-stage integer multiplier for the cappuccino execute unit. It accepts one l.mul/l.mulu operation per cycle and produces the low operand-width bits of the product. It drives the `mul_result` operand of the RF writeback mux, alongside the `op_mul` writeback select. Optional overflow/carry flags feed the SR flag logic.

## Interface
- `OPTION_OPERAND_WIDTH`, 32: operand and result width W; must be even.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous and active-high.
- `padv_execute_i`  in  1  execute pipeline advance; an op is only accepted on an advancing cycle.
- `op_mul_i`  in  1  multiply op present in execute.
- `op_mul_signed_i`  in  1  1 = l.mul (signed), 0 = l.mulu (unsigned).
- `flush_i`  in  1  pipeline flush (exception or branch mispredict).
- `a_i`  in  W  operand A.
- `b_i`  in  W  operand B.
- `mul_result_o`  out  W  low W bits of the product; holds the last result.
- `mul_valid_o`  out  1  one-cycle pulse marking a new `mul_result_o`.
- `mul_overflow_o`  out  1  signed overflow; qualified by `mul_valid_o` and by op signed.
- `mul_carry_o`  out  1  unsigned carry; qualified by `mul_valid_o` and by op unsigned.

## Operation
- Accept: `accept = op_mul_i & padv_execute_i & ~flush_i`.
- Stage 1 (S1): on accept, register `a_i`, `b_i` and the signed bit, and set `v1`. On cycles without accept, `v1` is cleared.
- Stage 2 (S2): split each operand into halves, high and low, each W/2 bits. Register four unsigned partial products, `ah*bh`, `ah*bl`, `al*bh` and `al*bl`, each W bits. `v2` is loaded from `v1`.
- Stage 3 (S3):
  - Sum the partial products into the 2W-bit unsigned product P.
  - For signed ops, apply the correction P_s = P − (a[W-1] ? b<<W : 0) − (b[W-1] ? a<<W : 0), modulo 2^2W.
  - `mul_result_o` = low W bits of the chosen product; low bits are identical for signed and unsigned.
  - `mul_valid_o` is loaded from `v2`.
- `mul_result_o` and the flags update only when `v2` is set; otherwise they hold.
- Flags:
  - Overflow = 1 when the signed op's P_s[2W-1:W-1] is not all-zeros or all-ones.
  - Carry = 1 when the unsigned op's P[2W-1:W] is nonzero.
  - The flag that does not apply to the current op's signedness is 0.
- Flush: clears `v1`, `v2` and `mul_valid_o` at the edge. Data registers are left unchanged, and `mul_result_o` keeps its old value.
- Flush together with `op_mul_i`: flush wins and nothing is accepted.
- The pipeline is not stalled by `padv_execute_i` deasserting. Ops already in flight always drain; control holds the writeback until `mul_valid_o`.

## Timing
- Latency: an op accepted at edge E0 yields `mul_valid_o` = 1 in the cycle after edge E0+2. `OR1K_MUL_LATENCY` = 3 edges.
- Throughput: one op per cycle. Back-to-back accepts give back-to-back valid pulses, in order.
- Reset: `v1`, `v2`, `mul_valid_o`, `mul_result_o`, `mul_overflow_o` and `mul_carry_o` are all 0 after the reset edge.
- Reset mid-flight discards all in-flight ops; no stale valid pulse appears after reset.
- No combinational paths from inputs to outputs.

## Configuration
- `OR1K_MUL_FLAGS_EN` defined:
  - S2 keeps all four partial products.
  - S3 builds the full 2W-bit product with sign correction.
  - The flag outputs are live.
- `OR1K_MUL_FLAGS_EN` undefined:
  - S2 keeps `al*bl` in full, plus only the low W/2 bits of `ah*bl` and `al*bh`.
  - `ah*bh` and the sign correction are omitted.
  - `mul_overflow_o` and `mul_carry_o` are tied to 0.
  - `mul_result_o` and all timing are identical to the flags-enabled build.

## Structure
- `or1k-defines.v` holds `OR1K_MUL_LATENCY` (3) and the `OR1K_MUL_FLAGS_EN` switch.
- One sub-module, `or1k_mul_pp_stage`: the registered S2 partial-product array, parameterised on W, with its own flags generate.
- The top level holds S1, S3, the valid chain and the flag logic.

## Test plan
- Unsigned 0x00000003 × 0x00000005, accepted at E0 → `mul_valid_o` pulses after E2 with result 0x0000000F, carry 0, overflow 0.
- Unsigned 0xFFFFFFFF × 0x00000002 → result 0xFFFFFFFE, carry 1. The same operands signed → 0xFFFFFFFE, overflow 0.
- Signed 0x40000000 × 0x00000002 → result 0x80000000, overflow 1. Signed 0x80000000 × 0xFFFFFFFF → 0x80000000, overflow 1.
- Three ops on consecutive advancing cycles (2×3, 4×5, 6×7) → three consecutive valid cycles carrying 6, 20, 42 in order.
- Op accepted, then `flush_i` one cycle later → no valid pulse, `mul_result_o` keeps its prior value. `flush_i` together with `op_mul_i` → nothing accepted.
- `rst` asserted one cycle after accept → all outputs 0 and no valid pulse. With `OR1K_MUL_FLAGS_EN` undefined, repeating the 0xFFFFFFFF × 2 case → same result, flags 0.

Source files
------------

// File: rtl/or1k_mul_pipelined_cappuccino_pkg.sv
// Shared constants for the cappuccino pipelined multiplier.
// OR1K_MUL_FLAGS_EN (define) enables the overflow/carry flag datapath.
package or1k_mul_pipelined_cappuccino_pkg;

  // Edges from accept to the registered valid pulse
  localparam int unsigned OR1K_MUL_LATENCY      = 3;
  localparam int unsigned OPERAND_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/or1k_mul_pipelined_cappuccino_if.sv
// Execute-unit <-> multiplier signal bundle; master drives operands, slave returns results.
interface or1k_mul_pipelined_cappuccino_if
  import or1k_mul_pipelined_cappuccino_pkg::*;
#(
  parameter int unsigned W = OPERAND_WIDTH_DEFAULT
);

  logic         padv_execute_i;
  logic         op_mul_i;
  logic         op_mul_signed_i;
  logic         flush_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [W-1:0] mul_result_o;
  logic         mul_valid_o;
  logic         mul_overflow_o;
  logic         mul_carry_o;

  modport master (
    output padv_execute_i, op_mul_i, op_mul_signed_i, flush_i, a_i, b_i,
    input  mul_result_o, mul_valid_o, mul_overflow_o, mul_carry_o
  );

  modport slave (
    input  padv_execute_i, op_mul_i, op_mul_signed_i, flush_i, a_i, b_i,
    output mul_result_o, mul_valid_o, mul_overflow_o, mul_carry_o
  );

endinterface

// File: rtl/or1k_mul_pp_stage.sv
// Registered half-word partial-product array (multiplier stage 2).
// Without OR1K_MUL_FLAGS_EN only the bits feeding the low W result bits are kept.
module or1k_mul_pp_stage
  import or1k_mul_pipelined_cappuccino_pkg::*;
#(
  parameter int unsigned W = OPERAND_WIDTH_DEFAULT,
`ifdef OR1K_MUL_FLAGS_EN
  localparam int unsigned PPW = W
`else
  localparam int unsigned PPW = W / 2
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
`ifdef OR1K_MUL_FLAGS_EN
  output logic [W-1:0]   pp_hh,
`endif
  output logic [PPW-1:0] pp_hl,
  output logic [PPW-1:0] pp_lh,
  output logic [W-1:0]   pp_ll
);

  localparam int unsigned H = W / 2;

  logic [H-1:0] ah, al, bh, bl;

  assign ah = a[W-1:H];
  assign al = a[H-1:0];
  assign bh = b[W-1:H];
  assign bl = b[H-1:0];

  // Cross terms are truncated to PPW; in the reduced build only their low half reaches the result
  always_ff @(posedge clk) begin
    if (rst) begin
      pp_ll <= '0;
      pp_hl <= '0;
      pp_lh <= '0;
`ifdef OR1K_MUL_FLAGS_EN
      pp_hh <= '0;
`endif
    end else if (en) begin
      pp_ll <= W'(al) * W'(bl);
      pp_hl <= PPW'(ah) * PPW'(bl);
      pp_lh <= PPW'(al) * PPW'(bh);
`ifdef OR1K_MUL_FLAGS_EN
      pp_hh <= W'(ah) * W'(bh);
`endif
    end
  end

endmodule

// File: rtl/or1k_mul_pipelined_cappuccino.sv
// Three-stage pipelined l.mul/l.mulu unit: S1 operand capture, S2 partial products, S3 sum + flags.
// OR1K_MUL_FLAGS_EN (define) builds the full product and drives overflow/carry.
module or1k_mul_pipelined_cappuccino
  import or1k_mul_pipelined_cappuccino_pkg::*;
#(
  parameter int unsigned OPTION_OPERAND_WIDTH = OPERAND_WIDTH_DEFAULT
) (
  input logic                          clk,
  input logic                          rst,
  or1k_mul_pipelined_cappuccino_if.slave mul
);

  localparam int unsigned W  = OPTION_OPERAND_WIDTH;
  localparam int unsigned H  = W / 2;
  localparam int unsigned W2 = 2 * W;

  logic         accept;
  logic         flush;
  logic         s2_load;
  logic         v1, v2;
  logic [W-1:0] a1, b1;
  logic [W-1:0] pp_ll;
  logic [W-1:0] res_c;

  assign flush   = mul.flush_i;
  assign accept  = mul.op_mul_i & mul.padv_execute_i & ~flush;
  assign s2_load = v1 & ~flush;

  // S1: operand capture
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a1 <= mul.a_i;
        b1 <= mul.b_i;
      end
    end
  end

  // S2 valid
  always_ff @(posedge clk) begin
    if (rst) v2 <= 1'b0;
    else     v2 <= s2_load;
  end

`ifdef OR1K_MUL_FLAGS_EN
  logic          sgn1, sgn2;
  logic [W-1:0]  a2, b2;
  logic [W-1:0]  pp_hh, pp_hl, pp_lh;
  logic [W2-1:0] prod_c;
  logic [W-1:0]  hi_s_c;
  logic          ovf_c, carry_c;

  // Signedness and raw operands ride along to S3 for the sign correction
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn1 <= 1'b0;
      sgn2 <= 1'b0;
      a2   <= '0;
      b2   <= '0;
    end else begin
      if (accept) sgn1 <= mul.op_mul_signed_i;
      if (s2_load) begin
        sgn2 <= sgn1;
        a2   <= a1;
        b2   <= b1;
      end
    end
  end

  or1k_mul_pp_stage #(.W(W)) u_pp (
    .clk   (clk),
    .rst   (rst),
    .en    (s2_load),
    .a     (a1),
    .b     (b1),
    .pp_hh (pp_hh),
    .pp_hl (pp_hl),
    .pp_lh (pp_lh),
    .pp_ll (pp_ll)
  );

  // Sign correction only touches the upper half, so only that half is recomputed
  always_comb begin
    prod_c  = (W2'(pp_hh) << W) + (W2'(pp_hl) << H) + (W2'(pp_lh) << H) + W2'(pp_ll);
    hi_s_c  = prod_c[W2-1:W] - (a2[W-1] ? b2 : '0) - (b2[W-1] ? a2 : '0);
    ovf_c   = sgn2 & ~((&{hi_s_c, prod_c[W-1]}) | ~(|{hi_s_c, prod_c[W-1]}));
    carry_c = ~sgn2 & (|prod_c[W2-1:W]);
    res_c   = prod_c[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul.mul_overflow_o <= 1'b0;
      mul.mul_carry_o    <= 1'b0;
    end else if (v2 && !flush) begin
      mul.mul_overflow_o <= ovf_c;
      mul.mul_carry_o    <= carry_c;
    end
  end
`else
  logic [H-1:0] pp_hl, pp_lh;
  logic [H-1:0] mid_c;

  or1k_mul_pp_stage #(.W(W)) u_pp (
    .clk   (clk),
    .rst   (rst),
    .en    (s2_load),
    .a     (a1),
    .b     (b1),
    .pp_hl (pp_hl),
    .pp_lh (pp_lh),
    .pp_ll (pp_ll)
  );

  // Only the low halves of the cross terms land inside the low W product bits
  always_comb begin
    mid_c = pp_hl + pp_lh;
    res_c = pp_ll + {mid_c, {H{1'b0}}};
  end

  assign mul.mul_overflow_o = 1'b0;
  assign mul.mul_carry_o    = 1'b0;
`endif

  // S3: registered result, held between ops
  always_ff @(posedge clk) begin
    if (rst) begin
      mul.mul_valid_o  <= 1'b0;
      mul.mul_result_o <= '0;
    end else begin
      mul.mul_valid_o <= v2 & ~flush;
      if (v2 && !flush) mul.mul_result_o <= res_c;
    end
  end

endmodule
